// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- request/response bus of the sequential ALU.
//
// Handshake rules:
//   request : a_in/b_in/command_in are taken on a rising edge where
//             in_valid && in_ready. The requester holds them stable while
//             in_valid is high. in_ready is high only while the ALU is idle.
//   response: d_out/zero/err are valid while out_valid is high. They stay
//             stable until a rising edge where out_valid && out_ready.
//
// Signals (WIDTH = operand width):
//   a_in, b_in  [WIDTH-1:0]  operands                     master -> slave
//   command_in  [3:0]        opcode                       master -> slave
//   in_valid                 request present              master -> slave
//   in_ready                 ALU can take a request       slave  -> master
//   out_valid                result valid                 slave  -> master
//   out_ready                consumer takes the result    master -> slave
//   zero                     result is all zeros          slave  -> master
//   err                      divide error                 slave  -> master
// d_out is a tri-stated plain port of alu_seq and is not part of this bundle.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       command_in;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             err;

  modport master (
    output a_in, b_in, command_in, in_valid, out_ready,
    input  in_ready, out_valid, zero, err
  );

  modport slave (
    input  a_in, b_in, command_in, in_valid, out_ready,
    output in_ready, out_valid, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with a valid/ready request/response handshake.
//
// Single-cycle ops (ADD, INC, SUB, DEC, MUL, shifts, bitwise) are computed
// from the inputs on the accept edge and registered straight into the result
// register. DIV is an unsigned restoring divider producing one quotient bit
// per cycle (quotient in the low half of d_out, remainder in the high half).
//
// Build option: define ALU_SEQ_DIV_EN to include the iterative divider and
// the DIV_BUSY state. Without it, DIV completes in one cycle with d_out = 0
// and err = 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   oe         output enable for d_out (affects only the d_out drivers)
//   d_out      [2*WIDTH-1:0] registered result, high-impedance when oe = 0
//   dbg_state  [1:0] current FSM state (0 IDLE, 1 DIV_BUSY, 2 DONE)
//   bus        alu_seq_if slave: operands, opcode, handshake, zero, err
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oe,
  output wire  [2*WIDTH-1:0]   d_out,
  output logic [1:0]           dbg_state,
  alu_seq_if.slave             bus
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_INV  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_XNOR = 4'hE;
  localparam logic [3:0] OP_BUF  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
`ifdef ALU_SEQ_DIV_EN
    S_DIV_BUSY = 2'd1,
`endif
    S_DONE     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

`ifdef ALU_SEQ_DIV_EN
  localparam int CW = $clog2(WIDTH);
  // rem holds the partial remainder; quo starts as the dividend and shifts
  // left one bit per iteration, the freed LSBs collecting quotient bits.
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [CW-1:0]        cnt_q, cnt_d;
`endif

  // ------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the request inputs.
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       sub_ext;   // bit WIDTH set means a < subtrahend
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   alu_res;

  always_comb begin
    opnd    = ((bus.command_in == OP_INC) || (bus.command_in == OP_DEC))
              ? WIDTH'(1) : bus.b_in;
    add_ext = {1'b0, bus.a_in} + {1'b0, opnd};
    sub_ext = {1'b0, bus.a_in} - {1'b0, opnd};
    prod    = {{WIDTH{1'b0}}, bus.a_in} * {{WIDTH{1'b0}}, bus.b_in};
    alu_res = '0;
    unique case (bus.command_in)
      OP_ADD, OP_INC: alu_res = {{(WIDTH-1){1'b0}}, add_ext};
      OP_SUB, OP_DEC: alu_res = {{(WIDTH-1){1'b0}}, sub_ext};
      OP_MUL:         alu_res = prod;
      OP_SHL:         alu_res = {{(WIDTH-1){1'b0}}, bus.a_in, 1'b0};
      OP_SHR:         alu_res = {{(WIDTH+1){1'b0}}, bus.a_in[WIDTH-1:1]};
      OP_AND:         alu_res = {{WIDTH{1'b0}}, bus.a_in & bus.b_in};
      OP_OR:          alu_res = {{WIDTH{1'b0}}, bus.a_in | bus.b_in};
      OP_INV:         alu_res = {{WIDTH{1'b0}}, ~bus.a_in};
      OP_NAND:        alu_res = {{WIDTH{1'b0}}, ~(bus.a_in & bus.b_in)};
      OP_NOR:         alu_res = {{WIDTH{1'b0}}, ~(bus.a_in | bus.b_in)};
      OP_XOR:         alu_res = {{WIDTH{1'b0}}, bus.a_in ^ bus.b_in};
      OP_XNOR:        alu_res = {{WIDTH{1'b0}}, ~(bus.a_in ^ bus.b_in)};
      OP_BUF:         alu_res = {{WIDTH{1'b0}}, bus.a_in};
      default:        alu_res = '0;   // DIV is handled by the FSM
    endcase
  end

  // ------------------------------------------------------------------
  // FSM next state. Every result is written through the load path so
  // zero and err are always derived from the value being registered.
  // ------------------------------------------------------------------
  logic                 load;
  logic [2*WIDTH-1:0]   load_val;
  logic                 load_err;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]       trial;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    load     = 1'b0;
    load_val = '0;
    load_err = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    trial    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.command_in == OP_DIV) begin
`ifdef ALU_SEQ_DIV_EN
            if (bus.b_in == '0) begin
              load     = 1'b1;
              load_val = {bus.a_in, {WIDTH{1'b1}}};
              load_err = 1'b1;
              state_d  = S_DONE;
            end else begin
              rem_d   = '0;
              quo_d   = bus.a_in;
              dvs_d   = bus.b_in;
              cnt_d   = '0;
              state_d = S_DIV_BUSY;
            end
`else
            load     = 1'b1;
            load_val = '0;
            load_err = 1'b1;
            state_d  = S_DONE;
`endif
          end else begin
            load     = 1'b1;
            load_val = alu_res;
            state_d  = S_DONE;
          end
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV_BUSY: begin
        // Shift the next dividend bit into the remainder and subtract the
        // divisor; a clear MSB of the trial means the subtraction fits.
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          load     = 1'b1;
          load_val = {rem_d, quo_d};
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      result_d = load_val;
      zero_d   = (load_val == '0);
      err_d    = load_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;
  assign d_out         = oe ? result_q : {(2*WIDTH){1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq at WIDTH = 8.
// Directed vector table, hand-written multi-cycle sequences (backpressure,
// output enable, resets mid-operation) and random requests checked against
// an arithmetic reference model. Follows the ALU_SEQ_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic oe;
  wire  [2*W-1:0] d_out;
  logic [1:0] dbg_state;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .oe        (oe),
    .d_out     (d_out),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W+1:0] exp_q[$];   // {err, zero, d_out}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample point is 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [3:0] cmd, input logic [7:0] a8, input logic [7:0] b8,
                                output logic [15:0] d, output logic z, output logic e, output int lat);
    int a, b, r;
    a = int'(a8);
    b = int'(b8);
    r = 0;
    e = 1'b0;
    lat = 1;
    case (cmd)
      4'h0: r = a + b;
      4'h1: r = a + 1;
      4'h2: r = ((a - b) & 255) + ((a < b) ? 256 : 0);
      4'h3: r = ((a - 1) & 255) + ((a < 1) ? 256 : 0);
      4'h4: r = a * b;
      4'h5: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 0) begin
          r = a * 256 + 255;
          e = 1'b1;
        end else begin
          r = (a % b) * 256 + a / b;
          lat = W + 1;
        end
`else
        r = 0;
        e = 1'b1;
`endif
      end
      4'h6: r = a * 2;
      4'h7: r = a / 2;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = 255 - a;
      4'hB: r = 255 - (a & b);
      4'hC: r = 255 - (a | b);
      4'hD: r = a ^ b;
      4'hE: r = 255 - (a ^ b);
      default: r = a;
    endcase
    d = 16'(r);
    z = (r == 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one request, measure latency and busy cycles, check the result,
  // optionally stall out_ready for 'stall' cycles, then check return to idle.
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_d, input logic exp_z,
                        input logic exp_e, input int exp_lat, input int stall);
    int lat;
    int low;
    wait_idle();
    bus.command_in = cmd;
    bus.a_in       = a;
    bus.b_in       = b;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    // Inputs change after the accept edge; the operation must ignore them.
    bus.in_valid   = 1'b0;
    bus.a_in       = 8'($urandom);
    bus.b_in       = 8'($urandom);
    bus.command_in = 4'($urandom);
    lat = 1;
    low = (bus.in_ready == 1'b0) ? 1 : 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (bus.in_ready == 1'b0) low++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/busy"}, 32'(low), 32'(exp_lat));
    check({tag, "/d_out"}, 32'(d_out), 32'(exp_d));
    check({tag, "/zero_err"}, 32'({bus.zero, bus.err}), 32'({exp_z, exp_e}));
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        check({tag, "/hold"}, 32'({bus.out_valid, bus.zero, bus.err, d_out}),
              32'({1'b1, exp_z, exp_e, exp_d}));
      end
      bus.out_ready = 1'b1;
    end
    tick();
    check({tag, "/to_idle"}, 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  // ---------------- main test ----------------
  initial begin
    logic [3:0]  rcmd;
    logic [7:0]  ra, rb;
    logic [15:0] md;
    logic        mz, me;
    int          ml;
    logic [2*W+1:0] ex;
    logic        hiz;
    int          seen;

    rst            = 1'b1;
    oe             = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.command_in = '0;

    // Reset state from the first edge with rst high.
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_flags", 32'({bus.out_valid, bus.zero, bus.err}), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b0;

    vecs[0]  = '{4'h0, 8'hFF, 8'h01, 16'h0100, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'h2, 8'h05, 8'h07, 16'h01FE, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'h4, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1};
`ifdef ALU_SEQ_DIV_EN
    vecs[3]  = '{4'h5, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 9};
    vecs[4]  = '{4'h5, 8'h33, 8'h00, 16'h33FF, 1'b0, 1'b1, 1};
`else
    vecs[3]  = '{4'h5, 8'd200, 8'd7, 16'h0000, 1'b1, 1'b1, 1};
    vecs[4]  = '{4'h5, 8'h33, 8'h00, 16'h0000, 1'b1, 1'b1, 1};
`endif
    vecs[5]  = '{4'h1, 8'hFF, 8'h00, 16'h0100, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'h3, 8'h00, 8'h00, 16'h01FF, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'h6, 8'h81, 8'h00, 16'h0102, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h7, 8'h81, 8'h00, 16'h0040, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h8, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1};
    vecs[10] = '{4'h9, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[11] = '{4'hA, 8'h0F, 8'h00, 16'h00F0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'hB, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0, 1};
    vecs[13] = '{4'hC, 8'h00, 8'h00, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[14] = '{4'hE, 8'hA5, 8'h5A, 16'h0000, 1'b1, 1'b0, 1};
    vecs[15] = '{4'hF, 8'h5A, 8'h00, 16'h005A, 1'b0, 1'b0, 1};

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b,
             vecs[i].d, vecs[i].z, vecs[i].e, vecs[i].lat, 0);
    end

`ifdef ALU_SEQ_DIV_EN
    // Reset in the 4th DIV_BUSY cycle: aborted, no result ever appears.
    wait_idle();
    bus.command_in = 4'h5;
    bus.a_in       = 8'd200;
    bus.b_in       = 8'd7;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("div_abort_busy", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("div_abort_hs", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
    check("div_abort_d", 32'(d_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("div_abort_no_result", 32'(seen), 32'd0);
`endif

    // Backpressure on XOR with another request pending during DONE.
    wait_idle();
    bus.command_in = 4'hD;
    bus.a_in       = 8'hF0;
    bus.b_in       = 8'hF0;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    tick();
    bus.command_in = 4'h0;
    bus.a_in       = 8'h01;
    bus.b_in       = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i),
            32'({bus.out_valid, bus.in_ready, bus.zero, bus.err, d_out}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));

    // Output enable: d_out floats while everything else carries on.
    wait_idle();
    bus.command_in = 4'h0;
    bus.a_in       = 8'h12;
    bus.b_in       = 8'h34;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    oe = 1'b0;
    #1;
    hiz = (d_out === 16'bzzzz_zzzz_zzzz_zzzz);
    check("oe0_hiz", 32'(hiz), 32'd1);
    check("oe0_flags", 32'({bus.out_valid, bus.zero, bus.err}), 32'(3'b100));
    tick();
    check("oe0_hold", 32'({bus.out_valid, bus.in_ready}), 32'(2'b10));
    oe = 1'b1;
    #1;
    check("oe1_d_out", 32'(d_out), 32'h0046);

    // Reset while a result is waiting in DONE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_hs", 32'({bus.out_valid, bus.in_ready, bus.zero, bus.err}), 32'(4'b0100));
    check("rst_done_d_out", 32'(d_out), 32'd0);
    bus.out_ready = 1'b1;

    // Reset wins over a simultaneous accept.
    bus.command_in = 4'h0;
    bus.a_in       = 8'h01;
    bus.b_in       = 8'h02;
    bus.in_valid   = 1'b1;
    rst            = 1'b1;
    tick();
    check("rst_prio_hs", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("rst_prio_after", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      rcmd = 4'($urandom_range(0, 15));
      ra   = 8'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(rcmd, ra, rb, md, mz, me, ml);
      exp_q.push_back({me, mz, md});
      ex = exp_q.pop_front();
      run_op($sformatf("rnd%0d_op%0h", i, rcmd), rcmd, ra, rb, ex[15:0], ex[16], ex[17],
             ml, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4 to 32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a_in  input  WIDTH  operand A.
REQ-005 b_in  input  WIDTH  operand B.
REQ-006 command_in  input  4  opcode: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 MUL, 5 DIV, 6 SHL, 7 SHR, 8 AND, 9 OR, A INV, B NAND, C NOR, D XOR, E XNOR, F BUF.
REQ-007 in_valid  input  1  request present on a_in, b_in and command_in.
REQ-008 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-009 out_valid  output  1  result on d_out, zero and err is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 oe  input  1  output enable for d_out.
REQ-012 d_out  output  2*WIDTH  registered result when oe=1; high-impedance on all bits when oe=0.
REQ-013 zero  output  1  registered result equals 0.
REQ-014 err  output  1  divide by zero, or DIV opcode when the divider is compiled out.

Function
REQ-015 Accept rule: a request is accepted on a rising edge where in_valid and in_ready are both 1; a_in, b_in and command_in are latched on that edge.
REQ-016 FSM states are IDLE, DIV_BUSY and DONE.
REQ-017 FSM transitions:
- IDLE to DONE on accept of a non-DIV opcode.
- IDLE to DIV_BUSY on accept of DIV with b non-zero.
- IDLE to DONE on accept of DIV with b = 0.
- DIV_BUSY to DONE after exactly WIDTH iterations.
- DONE to IDLE on out_ready.
REQ-018 Latency from accept edge to out_valid high is 1 cycle for non-DIV opcodes, 1 cycle for DIV by zero, and WIDTH+1 cycles for DIV.
REQ-019 out_valid is high only in DONE.
REQ-020 d_out, zero and err are held stable while out_valid=1 and out_ready=0.
REQ-021 Throughput is at most one request per 2 cycles; there is no input acceptance in DONE or DIV_BUSY.
REQ-022 ADD and INC produce a zero-extended (WIDTH+1)-bit sum; bit WIDTH is the carry.
REQ-023 SUB and DEC produce the WIDTH-bit wrap-around difference in the low bits; bit WIDTH is the borrow (a < subtrahend).
REQ-024 MUL produces the full unsigned 2*WIDTH-bit product in a single cycle.
REQ-025 DIV is unsigned restoring division, one quotient bit per cycle; quotient goes in the low WIDTH bits and remainder in the high WIDTH bits.
REQ-026 DIV with b = 0 gives quotient all ones, remainder = a, and err=1.
REQ-027 SHL and SHR shift a by 1 and zero-fill; SHL keeps the shifted-out bit in bit WIDTH.
REQ-028 AND, OR, INV, NAND, NOR, XOR, XNOR and BUF are bitwise over WIDTH bits.
REQ-029 For every opcode, all unused upper bits of d_out are 0.
REQ-030 zero and err are computed from the registered result and are valid with out_valid; err is 0 for every opcode except as in REQ-026 and REQ-036.
REQ-031 Changes to input ports after the accept edge have no effect on an operation in flight.
REQ-032 oe affects only the d_out drivers; it has no effect on the FSM, the handshake, zero or err.

Reset
REQ-033 rst high on a clock edge forces state IDLE, result register 0, out_valid 0, zero 0 and err 0.
REQ-034 in_ready is 1 from the first edge with rst high.
REQ-035 rst aborts any DIV_BUSY or DONE operation with no result delivered; rst takes priority over a simultaneous accept.

Configuration
REQ-036 Macro ALU_SEQ_DIV_EN:
- Defined: the iterative divider and the DIV_BUSY state are present.
- Undefined: the divider and DIV_BUSY are absent; DIV goes IDLE to DONE in 1 cycle with d_out = 0 and err = 1, and all other opcodes are unchanged.

Verification
REQ-037 The bench shall cover these scenarios, all at WIDTH=8, oe=1, out_ready=1:
- ADD a=0xFF, b=0x01 -> d_out=0x0100, zero=0, err=0, out_valid 1 cycle after accept.
- SUB a=0x05, b=0x07 -> d_out=0x01FE; then MUL a=0xFF, b=0xFF -> d_out=0xFE01.
- DIV a=200, b=7 (ALU_SEQ_DIV_EN defined) -> in_ready low for 9 cycles, d_out=0x041C 9 cycles after accept, err=0; DIV a=0x33, b=0 -> d_out=0x33FF, err=1, 1-cycle latency.
- Backpressure: XOR a=0xF0, b=0xF0 with out_ready=0 for 5 cycles -> out_valid held, d_out=0x0000, zero=1, in_ready=0; completes on out_ready=1 and returns to IDLE.
- rst pulsed at the 4th DIV_BUSY cycle -> next cycle out_valid=0, in_ready=1, no result; oe=0 at any time -> d_out all Z.
